serial_disp_rx: RTL and testbench

Receive-side deserializer for the board's three-wire serial display bus (shift clock, data, latch enable) as driven onto `SEGLED_*` / `LED_*`. It samples the bus asynchronously from the system clock, shifts in one frame of `FRAME_BITS` bits, and presents the completed frame as a parallel word on the latch strobe. Uses:
- in simulation, as the bench-side model of the segment/LED shift-register chain;
- on a second board, to mirror the display contents.

---
 rtl/serial_disp_rx_if.sv | 43 ++++
 rtl/serial_disp_rx.sv | 148 ++++++++++++++
 tb/tb_serial_disp_rx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_disp_rx_if.sv
// Serial display bus plus the parallel frame outputs recovered from it.
interface serial_disp_rx_if #(
    parameter int unsigned FRAME_BITS = 64,
    parameter int unsigned CNT_W      = $clog2(FRAME_BITS + 2)
) ();

    // Pin-level serial bus, asynchronous to the receiver clock
    logic                  s_clk;
    logic                  s_do;
    logic                  s_pen;

    // Recovered frame and status
    logic [FRAME_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  frame_err;
    logic [15:0]           frame_cnt;
    logic [CNT_W-1:0]      bit_cnt;

    // Transmitter / observer side
    modport master (
        output s_clk,
        output s_do,
        output s_pen,
        input  frame_data,
        input  frame_valid,
        input  frame_err,
        input  frame_cnt,
        input  bit_cnt
    );

    // Receiver side
    modport slave (
        input  s_clk,
        input  s_do,
        input  s_pen,
        output frame_data,
        output frame_valid,
        output frame_err,
        output frame_cnt,
        output bit_cnt
    );

endinterface

// File: rtl/serial_disp_rx.sv
// Receive-side deserializer for the three-wire serial display bus
// (shift clock, data, latch enable). Oversamples the bus on clk,
// shifts in MSB-first and publishes a parallel frame on the latch rise.
module serial_disp_rx #(
    parameter int unsigned FRAME_BITS = 64,
    parameter int unsigned CNT_W      = $clog2(FRAME_BITS + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    serial_disp_rx_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

    // Frame progress, decoded from the bit counter (which is the state register)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    logic [1:0]            rst_pipe;
    logic                  rst_sync_n;

    logic [2:0]            sclk_pipe;
    logic [2:0]            pen_pipe;
    logic [1:0]            do_pipe;
    logic                  sclk_rise_c;
    logic                  pen_rise_c;

    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] shreg_nxt;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_nxt;
    logic [CNT_W-1:0]      cnt_shift_c;
    logic [FRAME_BITS-1:0] frame_data_q;
    logic [FRAME_BITS-1:0] frame_data_nxt;
    logic [15:0]           frame_cnt_q;
    logic [15:0]           frame_cnt_nxt;
    logic                  frame_valid_q;
    logic                  frame_valid_nxt;
    logic                  frame_err_q;
    logic                  frame_err_nxt;
    state_t                state_c;
    state_t                latch_state_c;

    function automatic state_t decode_state(input logic [CNT_W-1:0] cnt);
        state_t st;
        if (cnt == '0) begin
            st = ST_IDLE;
        end else if (cnt == CNT_OVER) begin
            st = ST_OVER;
        end else begin
            st = ST_SHIFT;
        end
        return st;
    endfunction

    // Reset asserts immediately, releases two clk edges after rstn rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];

    // Two-flop synchronizers; strobes get a third stage for edge detection.
    // Data taps the second stage so it lines up with the detected clock edge.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sclk_pipe <= '0;
            pen_pipe  <= '0;
            do_pipe   <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[1:0], bus.s_clk};
            pen_pipe  <= {pen_pipe[1:0], bus.s_pen};
            do_pipe   <= {do_pipe[0], bus.s_do};
        end
    end

    assign sclk_rise_c = sclk_pipe[1] & ~sclk_pipe[2];
    assign pen_rise_c  = pen_pipe[1] & ~pen_pipe[2];

    // State and output registers
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            frame_data_q  <= '0;
            frame_cnt_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            shreg_q       <= shreg_nxt;
            bit_cnt_q     <= bit_cnt_nxt;
            frame_data_q  <= frame_data_nxt;
            frame_cnt_q   <= frame_cnt_nxt;
            frame_valid_q <= frame_valid_nxt;
            frame_err_q   <= frame_err_nxt;
        end
    end

    // Next state: shift first, then let a coincident latch see the new bit
    always_comb begin
        shreg_nxt       = shreg_q;
        cnt_shift_c     = bit_cnt_q;
        bit_cnt_nxt     = bit_cnt_q;
        frame_data_nxt  = frame_data_q;
        frame_cnt_nxt   = frame_cnt_q;
        frame_valid_nxt = 1'b0;
        frame_err_nxt   = 1'b0;
        state_c         = decode_state(bit_cnt_q);

        if (sclk_rise_c) begin
            shreg_nxt = {shreg_q[FRAME_BITS-2:0], do_pipe[1]};
            case (state_c)
                ST_IDLE, ST_SHIFT: cnt_shift_c = bit_cnt_q + CNT_W'(1);
                ST_OVER:           cnt_shift_c = bit_cnt_q;
                default:           cnt_shift_c = '0;
            endcase
        end

        latch_state_c = decode_state(cnt_shift_c);
        bit_cnt_nxt   = cnt_shift_c;

        if (pen_rise_c) begin
            if (latch_state_c == ST_SHIFT && cnt_shift_c == CNT_FULL) begin
                frame_data_nxt  = shreg_nxt;
                frame_cnt_nxt   = frame_cnt_q + 16'd1;
                frame_valid_nxt = 1'b1;
            end else begin
                frame_err_nxt   = 1'b1;
            end
            bit_cnt_nxt = '0;
        end
    end

    assign bus.frame_data  = frame_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_serial_disp_rx.sv
// Bench for serial_disp_rx: directed vector table, hand-written corner
// sequences and random frames checked against a bit-queue model.
module tb_serial_disp_rx;

    localparam int unsigned FB = 64;
    localparam int unsigned CW = $clog2(FB + 2);

    logic clk;
    logic rstn;

    serial_disp_rx_if #(.FRAME_BITS(FB), .CNT_W(CW)) bus ();

    serial_disp_rx #(.FRAME_BITS(FB), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: bits received since the last latch, plus published state
    bit          m_q[$];
    logic [63:0] m_data;
    logic [15:0] m_cnt;

    typedef struct {
        int          nbits;
        logic [63:0] data;
        bit          same;
        int          exp_pre_cnt;
        bit          exp_v;
        bit          exp_e;
        logic [63:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_q();
        logic [63:0] v = '0;
        foreach (m_q[i]) v = {v[62:0], m_q[i]};
        return v;
    endfunction

    function automatic int exp_bitcnt();
        return (m_q.size() > FB + 1) ? FB + 1 : m_q.size();
    endfunction

    task automatic send_bit(input bit b);
        @(negedge clk);
        bus.s_do = b;
        repeat (2) @(negedge clk);
        bus.s_clk = 1'b1;
        m_q.push_back(b);
        repeat (3) @(negedge clk);
        bus.s_clk = 1'b0;
    endtask

    // Raise s_pen (optionally together with one last s_clk rise) and observe the pulse
    task automatic do_latch(input bit same, input bit b, input string tag,
                            output bit got_v, output bit got_e);
        bit          exp_v;
        int          lat;
        int          width;
        bit          both;
        got_v = 1'b0;
        got_e = 1'b0;
        lat   = 0;
        width = 0;
        both  = 1'b0;
        if (same) begin
            @(negedge clk);
            bus.s_do = b;
            repeat (2) @(negedge clk);
            bus.s_clk = 1'b1;
            m_q.push_back(b);
        end else begin
            @(negedge clk);
        end
        bus.s_pen = 1'b1;
        exp_v = (m_q.size() == FB);
        if (exp_v) begin
            m_data = pack_q();
            m_cnt  = m_cnt + 16'd1;
        end
        m_q.delete();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3 && same) bus.s_clk = 1'b0;
            if (k == 4) bus.s_pen = 1'b0;
            if (bus.frame_valid || bus.frame_err) begin
                if (width == 0) begin
                    lat   = k;
                    got_v = bus.frame_valid;
                    got_e = bus.frame_err;
                end
                width++;
                if (bus.frame_valid && bus.frame_err) both = 1'b1;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'd3);
        chk({tag, " pulse_width"}, 64'(width), 64'd1);
        chk({tag, " valid_and_err"}, 64'(both), 64'd0);
        chk({tag, " model_valid"}, 64'(got_v), 64'(exp_v));
        chk({tag, " model_err"}, 64'(got_e), 64'(!exp_v));
        chk({tag, " model_data"}, bus.frame_data, m_data);
        chk({tag, " model_cnt"}, 64'(bus.frame_cnt), 64'(m_cnt));
        chk({tag, " bit_cnt_cleared"}, 64'(bus.bit_cnt), 64'd0);
    endtask

    // Send nbits bits of data (MSB first, zero above bit 63), then latch
    task automatic run_frame(input int nbits, input logic [63:0] data, input bit same,
                             input string tag, output int pre_cnt,
                             output bit got_v, output bit got_e);
        int last;
        last = same ? 1 : 0;
        for (int i = nbits - 1; i >= last; i--) begin
            send_bit((i < 64) ? data[i] : 1'b0);
        end
        pre_cnt = int'(bus.bit_cnt);
        chk({tag, " pre_bit_cnt"}, 64'(pre_cnt), 64'(exp_bitcnt()));
        do_latch(same, data[0], tag, got_v, got_e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " frame_data"}, bus.frame_data, 64'd0);
        chk({tag, " frame_valid"}, 64'(bus.frame_valid), 64'd0);
        chk({tag, " frame_err"}, 64'(bus.frame_err), 64'd0);
        chk({tag, " frame_cnt"}, 64'(bus.frame_cnt), 64'd0);
        chk({tag, " bit_cnt"}, 64'(bus.bit_cnt), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pre;
        bit          gv;
        bit          ge;
        int          pulses;
        int          nb;
        int          r;
        bit          sm;
        logic [63:0] d;

        vecs[0] = '{64, 64'hDEAD_BEEF_0123_4567, 1'b0, 64, 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567, 16'd1};
        vecs[1] = '{63, 64'h0123_4567_89AB_CDEF, 1'b0, 63, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 16'd1};
        vecs[2] = '{65, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 16'd1};
        vecs[3] = '{0,  64'h0,                   1'b0, 0,  1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 16'd1};
        vecs[4] = '{64, 64'h0000_0000_0000_0001, 1'b0, 64, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 16'd2};
        vecs[5] = '{64, 64'hA5A5_5A5A_0F0F_F0F1, 1'b1, 63, 1'b1, 1'b0, 64'hA5A5_5A5A_0F0F_F0F1, 16'd3};
        vecs[6] = '{65, 64'h1234_5678_9ABC_DEF0, 1'b1, 64, 1'b0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F1, 16'd3};

        rstn      = 1'b0;
        bus.s_clk = 1'b0;
        bus.s_do  = 1'b0;
        bus.s_pen = 1'b0;
        m_data    = '0;
        m_cnt     = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_frame(vecs[i].nbits, vecs[i].data, vecs[i].same, tag, pre, gv, ge);
            chk({tag, " pre_cnt"}, 64'(pre), 64'(vecs[i].exp_pre_cnt));
            chk({tag, " valid"}, 64'(gv), 64'(vecs[i].exp_v));
            chk({tag, " err"}, 64'(ge), 64'(vecs[i].exp_e));
            chk({tag, " data"}, bus.frame_data, vecs[i].exp_data);
            chk({tag, " cnt"}, 64'(bus.frame_cnt), 64'(vecs[i].exp_cnt));
        end

        // Reset after 30 bits: partial frame dropped, no pulse, outputs cleared
        d = 64'hCAFE_F00D_0000_0000;
        for (int i = 63; i >= 34; i--) send_bit(d[i]);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        m_q.delete();
        m_data = '0;
        m_cnt  = '0;
        repeat (3) @(negedge clk);
        rstn   = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.frame_valid || bus.frame_err) pulses++;
        end
        chk("midreset no_pulse", 64'(pulses), 64'd0);
        run_frame(64, 64'hFFFF_0000_FFFF_0000, 1'b0, "postreset", pre, gv, ge);
        chk("postreset valid", 64'(gv), 64'd1);
        chk("postreset data", bus.frame_data, 64'hFFFF_0000_FFFF_0000);
        chk("postreset cnt", 64'(bus.frame_cnt), 64'd1);

        // Counter wrap from FFFF
        force dut.frame_cnt_q = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        run_frame(64, 64'h0F1E_2D3C_4B5A_6978, 1'b0, "wrap", pre, gv, ge);
        chk("wrap valid", 64'(gv), 64'd1);
        chk("wrap cnt", 64'(bus.frame_cnt), 64'd0);

        // Random frames against the queue model
        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(0, 9);
            nb = (r == 6) ? 63 : (r == 7) ? 65 : (r == 8) ? int'($urandom_range(0, 70)) : 64;
            sm = ($urandom_range(0, 3) == 0) && (nb > 0);
            d  = {$urandom, $urandom};
            run_frame(nb, d, sm, $sformatf("rnd%0d", n), pre, gv, ge);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
